// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
// The master samples the decode and status inputs and drives every datapath enable and select.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       dm_ready;
  logic       pc_wr;
  logic [1:0] pc_src;
  logic       ir_wr;
  logic       alu_src;
  logic [1:0] ext_op;
  logic [2:0] alu_ctr;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       mem_rd;
  logic       mem_wr;
  logic       illegal;
  logic       mem_err;
  logic [2:0] state;

  modport master (
    input  op, funct, zero, dm_ready,
    output pc_wr, pc_src, ir_wr, alu_src, ext_op, alu_ctr, reg_wr, reg_dst,
           wd_sel, mem_rd, mem_wr, illegal, mem_err, state
  );

  modport slave (
    output op, funct, zero, dm_ready,
    input  pc_wr, pc_src, ir_wr, alu_src, ext_op, alu_ctr, reg_wr, reg_dst,
           wd_sel, mem_rd, mem_wr, illegal, mem_err, state
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: sequences FETCH/DECODE/EXE/MEM/WB and drives the datapath
// controls from the current state and the op/funct latched in DECODE.
module mc_ctrl_fsm #(
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_ILL, C_ADDU, C_SUBU, C_SLT, C_SLTU, C_JR, C_ORI,
    C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_SLT  = 3'd3;
  localparam logic [2:0] ALU_SLTU = 3'd4;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_HI   = 2'd2;

  // The wait counter only ever needs to hold TIMEOUT-1; TIMEOUT=0 disables the abort.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  function automatic cls_e decode(input logic [5:0] o, input logic [5:0] f);
    cls_e c;
    c = C_ILL;
    case (o)
      OP_RTYPE: begin
        case (f)
          FN_ADDU: c = C_ADDU;
          FN_SUBU: c = C_SUBU;
          FN_SLT:  c = C_SLT;
          FN_SLTU: c = C_SLTU;
          FN_JR:   c = C_JR;
          default: c = C_ILL;
        endcase
      end
      OP_J:    c = C_J;
      OP_JAL:  c = C_JAL;
      OP_BEQ:  c = C_BEQ;
      OP_ORI:  c = C_ORI;
      OP_LUI:  c = C_LUI;
      OP_LW:   c = C_LW;
      OP_SW:   c = C_SW;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;

  cls_e       cls;
  logic       is_rtype;
  logic       timeout_hit;

  logic       pc_wr;
  logic [1:0] pc_src;
  logic       ir_wr;
  logic       alu_src;
  logic [1:0] ext_op;
  logic [2:0] alu_ctr;
  logic       reg_wr;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       mem_rd;
  logic       mem_wr;
  logic       illegal;
  logic       mem_err;

  // DECODE looks at the live IR; later states use the copy latched in DECODE.
  assign cls = (state_q == S_DECODE) ? decode(bus.op, bus.funct) : decode(op_q, funct_q);
  assign is_rtype = (cls == C_ADDU) || (cls == C_SUBU) || (cls == C_SLT) || (cls == C_SLTU);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = S_FETCH;
    cnt_d   = '0;
    op_d    = op_q;
    funct_d = funct_q;
    pc_wr   = 1'b0;
    pc_src  = 2'd0;
    ir_wr   = 1'b0;
    alu_src = 1'b0;
    ext_op  = EXT_ZERO;
    alu_ctr = ALU_ADD;
    reg_wr  = 1'b0;
    reg_dst = 2'd0;
    wd_sel  = 2'd0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    illegal = 1'b0;
    mem_err = 1'b0;

    // ALU setup is a function of the instruction alone, so it stays put from EXE through WB.
    if (state_q == S_EXE || state_q == S_MEM_RD || state_q == S_MEM_WR || state_q == S_WB) begin
      case (cls)
        C_ADDU:      alu_ctr = ALU_ADD;
        C_SUBU:      alu_ctr = ALU_SUB;
        C_SLT:       alu_ctr = ALU_SLT;
        C_SLTU:      alu_ctr = ALU_SLTU;
        C_BEQ:       alu_ctr = ALU_SUB;
        C_ORI:       begin alu_src = 1'b1; ext_op = EXT_ZERO; alu_ctr = ALU_OR;  end
        C_LUI:       begin alu_src = 1'b1; ext_op = EXT_HI;   alu_ctr = ALU_OR;  end
        C_LW, C_SW:  begin alu_src = 1'b1; ext_op = EXT_SIGN; alu_ctr = ALU_ADD; end
        default:     alu_ctr = ALU_ADD;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        pc_src  = 2'd0;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d    = bus.op;
        funct_d = bus.funct;
        case (cls)
          C_J: begin
            pc_wr  = 1'b1;
            pc_src = 2'd2;
          end
          C_JAL: begin
            pc_wr   = 1'b1;
            pc_src  = 2'd2;
            reg_wr  = 1'b1;
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
          C_JR: begin
            pc_wr  = 1'b1;
            pc_src = 2'd3;
          end
          C_ILL:   illegal = 1'b1;
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (cls)
          C_LW:    state_d = S_MEM_RD;
          C_SW:    state_d = S_MEM_WR;
          C_BEQ: begin
            pc_src  = 2'd1;
            pc_wr   = bus.zero;
            state_d = S_FETCH;
          end
          C_ADDU, C_SUBU, C_SLT, C_SLTU, C_ORI, C_LUI: state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_RD, S_MEM_WR: begin
        mem_rd = (state_q == S_MEM_RD);
        mem_wr = (state_q == S_MEM_WR);
        // A ready in the final allowed cycle still completes normally.
        if (bus.dm_ready) begin
          state_d = (state_q == S_MEM_RD) ? S_WB : S_FETCH;
        end else if (timeout_hit) begin
          mem_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          cnt_d   = (TIMEOUT == 0) ? '0 : cnt_q + CNT_W'(1);
          state_d = state_q;
        end
      end
      S_WB: begin
        reg_wr  = 1'b1;
        reg_dst = is_rtype ? 2'd1 : 2'd0;
        wd_sel  = (cls == C_LW) ? 2'd1 : 2'd0;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q    <= op_d;
    funct_q <= funct_d;
  end

  // Reset kills every write and pulse in the cycle it is seen, including a pending WB.
  assign bus.pc_wr   = pc_wr   & ~reset;
  assign bus.ir_wr   = ir_wr   & ~reset;
  assign bus.reg_wr  = reg_wr  & ~reset;
  assign bus.mem_rd  = mem_rd  & ~reset;
  assign bus.mem_wr  = mem_wr  & ~reset;
  assign bus.illegal = illegal & ~reset;
  assign bus.mem_err = mem_err & ~reset;
  assign bus.pc_src  = pc_src;
  assign bus.alu_src = alu_src;
  assign bus.ext_op  = ext_op;
  assign bus.alu_ctr = alu_ctr;
  assign bus.reg_dst = reg_dst;
  assign bus.wd_sel  = wd_sel;
  assign bus.state   = state_q;

endmodule
